// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scan
//  Description : 4x4 hex matrix keypad scanner. Strobes one row low per slot,
//                samples synchronized columns at the end of each slot, rejects
//                multi-key scans, debounces over whole scans and shifts each
//                committed key code into a 32-bit digit register.
//  Revision    : 1.0  initial release
// ============================================================================
module keypad_scan #(
  parameter int SCAN_DIV  = 65536,
  parameter int DEB_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clear,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [31:0] digits
);

  localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STAB_W = $clog2(DEB_SCANS + 1);

  localparam logic [CNT_W-1:0]  c_cnt_max  = CNT_W'(SCAN_DIV - 1);
  localparam logic [STAB_W-1:0] c_stab_max = STAB_W'(DEB_SCANS);
  localparam logic [STAB_W-1:0] c_stab_one = STAB_W'(1);
  localparam logic [1:0]        c_last_row = 2'd3;

  // Column synchronizer (idle level is all-high: no key pressed)
  logic [3:0]        r_col_meta;
  logic [3:0]        r_col_sync;

  // Scan timing
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_row;
  logic [3:0]        r_row_out;

  // Per-scan accumulator: pressed-key count (saturating at 2) and first code
  logic [1:0]        r_acc_cnt;
  logic [3:0]        r_acc_code;

  // Debounce: previous scan result and stability count
  logic              r_prev_valid;
  logic [3:0]        r_prev_code;
  logic [STAB_W-1:0] r_stab;

  // Committed key state and outputs
  logic              r_com_valid;
  logic [3:0]        r_com_code;
  logic              r_key_valid;
  logic [31:0]       r_digits;

  logic              w_tick;
  logic              w_close;
  logic [3:0]        w_pressed;
  logic [2:0]        w_row_hits;
  logic [1:0]        w_first_col;
  logic [2:0]        w_sum;
  logic [1:0]        w_acc_cnt_nx;
  logic [3:0]        w_acc_code_nx;
  logic              w_res_valid;
  logic [3:0]        w_res_code;
  logic              w_same;
  logic [STAB_W-1:0] w_stab_nx;
  logic              w_differs;
  logic              w_commit;

  // Hex legend of the keypad, indexed by row and column
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Slot end strobe and scan close
  assign w_tick  = en && (r_cnt == c_cnt_max);
  assign w_close = w_tick && (r_row == c_last_row);

  // Decode the sampled row: number of pressed columns and the lowest one
  always_comb begin
    w_pressed   = ~r_col_sync;
    w_row_hits  = {2'b00, w_pressed[0]} + {2'b00, w_pressed[1]}
                + {2'b00, w_pressed[2]} + {2'b00, w_pressed[3]};
    w_first_col = 2'd0;
    for (int c = 3; c >= 0; c--) begin
      if (w_pressed[c]) w_first_col = 2'(c);
    end
  end

  // Accumulator update including the row being sampled, and the scan result
  always_comb begin
    w_sum         = {1'b0, r_acc_cnt} + w_row_hits;
    w_acc_cnt_nx  = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    w_acc_code_nx = ((r_acc_cnt == 2'd0) && (w_row_hits != 3'd0)) ?
                    key_map(r_row, w_first_col) : r_acc_code;
    w_res_valid   = (w_acc_cnt_nx == 2'd1);
    w_res_code    = w_res_valid ? w_acc_code_nx : 4'h0;
  end

  // Debounce decision evaluated on the closing tick
  always_comb begin
    w_same    = (w_res_valid == r_prev_valid) && (w_res_code == r_prev_code);
    w_stab_nx = w_same ? ((r_stab == c_stab_max) ? c_stab_max : r_stab + c_stab_one)
                       : c_stab_one;
    w_differs = (w_res_valid != r_com_valid) ||
                (w_res_valid && (w_res_code != r_com_code));
    w_commit  = w_close && (w_stab_nx == c_stab_max) && w_differs;
  end

  // Two-stage synchronizer on the asynchronous column inputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col_meta <= 4'hF;
      r_col_sync <= 4'hF;
    end else begin
      r_col_meta <= col_in;
      r_col_sync <= r_col_meta;
    end
  end

  // Prescaler, row index and registered row drive; disabled means idle rows
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_row     <= 2'd0;
      r_row_out <= 4'hF;
    end else if (!en) begin
      r_cnt     <= '0;
      r_row     <= 2'd0;
      r_row_out <= 4'hF;
    end else begin
      r_cnt     <= w_tick ? '0 : r_cnt + CNT_W'(1);
      r_row     <= w_tick ? r_row + 2'd1 : r_row;
      r_row_out <= ~(4'b0001 << r_row);
    end
  end

  // Scan accumulator: fold in each row sample, clear when the scan closes
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      r_acc_cnt  <= 2'd0;
      r_acc_code <= 4'h0;
    end else if (w_close) begin
      r_acc_cnt  <= 2'd0;
      r_acc_code <= 4'h0;
    end else if (w_tick) begin
      r_acc_cnt  <= w_acc_cnt_nx;
      r_acc_code <= w_acc_code_nx;
    end
  end

  // Stability tracking across consecutive scan results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev_valid <= 1'b0;
      r_prev_code  <= 4'h0;
      r_stab       <= '0;
    end else if (w_close) begin
      r_prev_valid <= w_res_valid;
      r_prev_code  <= w_res_code;
      r_stab       <= w_stab_nx;
    end
  end

  // Commit of a debounced state change: pulse, code, held flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_com_valid <= 1'b0;
      r_com_code  <= 4'h0;
      r_key_valid <= 1'b0;
    end else begin
      r_key_valid <= w_commit && w_res_valid;
      if (w_commit) begin
        r_com_valid <= w_res_valid;
        if (w_res_valid) r_com_code <= w_res_code;
      end
    end
  end

  // Digit shift register; clear takes priority over a simultaneous entry
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_digits <= 32'h0;
    end else if (w_commit && w_res_valid) begin
      r_digits <= {r_digits[27:0], w_res_code};
    end
  end

  assign row_out   = r_row_out;
  assign key_code  = r_com_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_com_valid;
  assign digits    = r_digits;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scan
//  Description : Self-checking bench for keypad_scan. A keypad model drives
//                the columns from the row strobes; a scan-level reference
//                model predicts pulses, codes and digits per full scan.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_keypad_scan;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int SCAN_CYC = 4 * SCAN_DIV;

  typedef struct packed {
    logic       v;
    logic [3:0] c;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        clear = 1'b0;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [31:0] digits;

  logic [15:0] keys = 16'h0;
  logic        bounce_on = 1'b0;
  logic [3:0]  bounce_val = 4'hF;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_pulse_cyc = 0;

  // Reference model state
  res_t        hist[$];
  logic        m_held = 1'b0;
  logic [3:0]  m_code = 4'h0;
  logic [31:0] m_digits = 32'h0;

  // Legend by matrix position (row*4 + col)
  logic [3:0] code_of [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEB_SCANS(DEB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clear    (clear),
    .col_in   (col_in),
    .row_out  (row_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held),
    .digits   (digits)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive matrix: a pressed key pulls its column low while its row is driven
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
    if (bounce_on) col_in = bounce_val;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic res_t scan_of(input logic [15:0] k);
    res_t r;
    r = '0;
    if ($countones(k) == 1)
      for (int p = 0; p < 16; p++)
        if (k[p]) begin r.v = 1'b1; r.c = code_of[p]; end
    return r;
  endfunction

  function automatic logic [15:0] key_at(input int p);
    logic [15:0] one;
    one = 16'h1;
    return one << p;
  endfunction

  // One full scan with a constant key set; then predict and compare
  task automatic do_scan(input logic [15:0] k, input bit bounce, input bit clr);
    int         pulses;
    res_t       res;
    bit         stable;
    bit         differs;
    int         exp_p;
    logic [3:0] exp_row;
    logic [3:0] one;
    pulses = 0;
    one = 4'b0001;
    keys = k;
    bounce_on = bounce;
    for (int j = 0; j < SCAN_CYC; j++) begin
      bounce_val = (((j / 5) % 2) == 1) ? 4'h0 : 4'hF;
      if (clr && j == SCAN_CYC - 1) clear = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clear = 1'b0;
      exp_row = ~(one << (j / 4));
      chk("row_out", 32'(row_out), 32'(exp_row));
      if (key_valid) begin
        pulses++;
        last_pulse_cyc = cyc;
      end
    end
    bounce_on = 1'b0;
    // A bouncing scan only ever sees all-open or all-closed rows: no single key
    res = bounce ? res_t'(0) : scan_of(k);
    hist.push_back(res);
    if (hist.size() > DEB) void'(hist.pop_front());
    stable = (hist.size() == DEB);
    foreach (hist[i]) if (hist[i] != res) stable = 1'b0;
    differs = (res.v != m_held) || (res.v && res.c != m_code);
    exp_p = 0;
    if (stable && differs) begin
      if (res.v) begin
        exp_p    = 1;
        m_code   = res.c;
        m_held   = 1'b1;
        m_digits = {m_digits[27:0], res.c};
      end else begin
        m_held = 1'b0;
      end
    end
    if (clr) m_digits = 32'h0;
    chk("pulse_count", 32'(pulses), 32'(exp_p));
    chk("key_code", 32'(key_code), 32'(m_code));
    chk("key_held", 32'(key_held), 32'(m_held));
    chk("digits", digits, m_digits);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_row_out", 32'(row_out), 32'hF);
    chk("rst_key_code", 32'(key_code), 32'h0);
    chk("rst_key_valid", 32'(key_valid), 32'h0);
    chk("rst_key_held", 32'(key_held), 32'h0);
    chk("rst_digits", digits, 32'h0);
  endtask

  // Directed sequence followed by randomized key activity
  initial begin
    int press_cyc;
    int p1;
    int p2;
    int hold;
    int kind;
    int seq [9];
    logic [15:0] k;

    // Reset for three cycles
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;

    // Idle scans: row strobe pattern is checked inside every scan
    do_scan(16'h0, 1'b0, 1'b0);
    do_scan(16'h0, 1'b0, 1'b0);

    // Key 6 (row1, col2) from the start of a scan: one pulse within latency
    press_cyc = cyc;
    last_pulse_cyc = cyc + 100000;
    repeat (4) do_scan(key_at(6), 1'b0, 1'b0);
    chk("latency_ok", 32'((last_pulse_cyc - press_cyc) <= (2 + SCAN_CYC + DEB * SCAN_CYC + 1)), 32'h1);
    chk("digits_6", digits, 32'h6);
    repeat (2) do_scan(16'h0, 1'b0, 1'b0);

    // Clear while idle, then keys 1, 2, 3 with releases in between
    do_scan(16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      repeat (3) do_scan(key_at(i), 1'b0, 1'b0);
      repeat (3) do_scan(16'h0, 1'b0, 1'b0);
    end
    chk("digits_123", digits, 32'h123);

    // Nine more presses (codes 4..C): only the newest eight survive
    seq = '{4, 5, 6, 8, 9, 10, 3, 7, 11};
    foreach (seq[i]) begin
      repeat (2) do_scan(key_at(seq[i]), 1'b0, 1'b0);
      repeat (2) do_scan(16'h0, 1'b0, 1'b0);
    end
    chk("digits_last8", digits, 32'h56789ABC);

    // Bounce for one scan, then stable key A
    do_scan(16'h0, 1'b1, 1'b0);
    repeat (3) do_scan(key_at(3), 1'b0, 1'b0);
    chk("code_A", 32'(key_code), 32'hA);
    repeat (2) do_scan(16'h0, 1'b0, 1'b0);

    // Ghost pattern 1+5, then release 5 keeping 1
    repeat (3) do_scan(key_at(0) | key_at(5), 1'b0, 1'b0);
    repeat (3) do_scan(key_at(0), 1'b0, 1'b0);
    chk("code_1", 32'(key_code), 32'h1);
    repeat (2) do_scan(16'h0, 1'b0, 1'b0);

    // Hold key 8, disable for 10 cycles, re-enable: no repeat pulse
    repeat (3) do_scan(key_at(9), 1'b0, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("dis_row_out", 32'(row_out), 32'hF);
      chk("dis_no_pulse", 32'(key_valid), 32'h0);
      chk("dis_held", 32'(key_held), 32'h1);
    end
    en = 1'b1;
    repeat (3) do_scan(key_at(9), 1'b0, 1'b0);
    repeat (2) do_scan(16'h0, 1'b0, 1'b0);

    // Key D committed in the same cycle as clear
    do_scan(key_at(15), 1'b0, 1'b0);
    do_scan(key_at(15), 1'b0, 1'b1);
    chk("clear_digits", digits, 32'h0);
    chk("clear_code_D", 32'(key_code), 32'hD);
    repeat (2) do_scan(16'h0, 1'b0, 1'b0);

    // Randomized key sets, hold lengths and occasional clears
    for (int s = 0; s < 40; s++) begin
      kind = int'($urandom_range(0, 3));
      p1   = int'($urandom_range(0, 15));
      p2   = (p1 + 1 + int'($urandom_range(0, 14))) % 16;
      case (kind)
        0:       k = 16'h0;
        3:       k = key_at(p1) | key_at(p2);
        default: k = key_at(p1);
      endcase
      hold = int'($urandom_range(1, 4));
      for (int h = 0; h < hold; h++)
        do_scan(k, 1'b0, ($urandom_range(0, 7) == 0));
    end

    // Reset mid-scan with a key held: it must debounce again from scratch
    repeat (2) do_scan(16'h0, 1'b0, 1'b0);
    repeat (2) do_scan(key_at(13), 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    hist.delete();
    m_held   = 1'b0;
    m_code   = 4'h0;
    m_digits = 32'h0;
    rst_n = 1'b1;
    repeat (3) do_scan(key_at(13), 1'b0, 1'b0);
    chk("rehold_held", 32'(key_held), 32'h1);
    chk("rehold_digits", digits, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
